// File: rtl/bpu_update_queue_pkg.sv
// Shared types for the branch-predictor training write queue.
package bpu_update_queue_pkg;

    localparam int unsigned BTB_LINE_WIDTH      = 129;
    localparam int unsigned BTB_INDEX_WIDTH     = 9;
    // BHT index is stored at this width and trimmed to the configured width on replay
    localparam int unsigned BHT_INDEX_WIDTH_MAX = 16;

    typedef struct packed {
        logic                           v;
        logic [BHT_INDEX_WIDTH_MAX-1:0] index;
        logic [1:0]                     counter_select;
        logic                           inc;
        logic                           dec;
        logic                           valid_in;
    } bht_half_t;

    typedef struct packed {
        logic                       v;
        logic [BTB_LINE_WIDTH-1:0]  wmask;
        logic [BTB_INDEX_WIDTH-1:0] index;
        logic [BTB_LINE_WIDTH-1:0]  din;
    } btb_half_t;

    typedef struct packed {
        bht_half_t bht;
        btb_half_t btb;
    } entry_t;

endpackage

// File: rtl/bpu_update_queue_if.sv
// Request, write-port and status signals of the training write queue.
interface bpu_update_queue_if
    import bpu_update_queue_pkg::*;
#(
    parameter int unsigned DEPTH              = 4,
    parameter int unsigned BHTBTB_INDEX_WIDTH = 9
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic                          in_bht_write_enable;
    logic [BHTBTB_INDEX_WIDTH-1:0] in_bht_write_index;
    logic [1:0]                    in_bht_write_counter_select;
    logic                          in_bht_write_inc;
    logic                          in_bht_write_dec;
    logic                          in_bht_valid_in;
    logic                          in_btb_ce;
    logic                          in_btb_we;
    logic [BTB_LINE_WIDTH-1:0]     in_btb_wmask;
    logic [BTB_INDEX_WIDTH-1:0]    in_btb_write_index;
    logic [BTB_LINE_WIDTH-1:0]     in_btb_din;
    logic                          pred_read_busy;

    logic                          out_bht_write_enable;
    logic [BHTBTB_INDEX_WIDTH-1:0] out_bht_write_index;
    logic [1:0]                    out_bht_write_counter_select;
    logic                          out_bht_write_inc;
    logic                          out_bht_write_dec;
    logic                          out_bht_valid_in;
    logic                          out_btb_ce;
    logic                          out_btb_we;
    logic [BTB_LINE_WIDTH-1:0]     out_btb_wmask;
    logic [BTB_INDEX_WIDTH-1:0]    out_btb_write_index;
    logic [BTB_LINE_WIDTH-1:0]     out_btb_din;
    logic                          queue_full;
    logic [CW-1:0]                 queue_count;
    logic [31:0]                   drop_cnt;

    modport master (
        output in_bht_write_enable, in_bht_write_index, in_bht_write_counter_select,
               in_bht_write_inc, in_bht_write_dec, in_bht_valid_in,
               in_btb_ce, in_btb_we, in_btb_wmask, in_btb_write_index, in_btb_din,
               pred_read_busy,
        input  out_bht_write_enable, out_bht_write_index, out_bht_write_counter_select,
               out_bht_write_inc, out_bht_write_dec, out_bht_valid_in,
               out_btb_ce, out_btb_we, out_btb_wmask, out_btb_write_index, out_btb_din,
               queue_full, queue_count, drop_cnt
    );

    modport slave (
        input  in_bht_write_enable, in_bht_write_index, in_bht_write_counter_select,
               in_bht_write_inc, in_bht_write_dec, in_bht_valid_in,
               in_btb_ce, in_btb_we, in_btb_wmask, in_btb_write_index, in_btb_din,
               pred_read_busy,
        output out_bht_write_enable, out_bht_write_index, out_bht_write_counter_select,
               out_bht_write_inc, out_bht_write_dec, out_bht_valid_in,
               out_btb_ce, out_btb_we, out_btb_wmask, out_btb_write_index, out_btb_din,
               queue_full, queue_count, drop_cnt
    );

endinterface

// File: rtl/bpu_update_queue_sync_fifo_ptr.sv
// Wrap-bit read/write pointer pair with full/empty/occupancy decode.
module sync_fifo_ptr #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic [$clog2(DEPTH)-1:0]   wr_addr,
    output logic [$clog2(DEPTH)-1:0]   rd_addr
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] rd_ptr;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + CW'(1);
            if (pop)  rd_ptr <= rd_ptr + CW'(1);
        end
    end

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign count   = wr_ptr - rd_ptr;
    assign wr_addr = wr_ptr[AW-1:0];
    assign rd_addr = rd_ptr[AW-1:0];

endmodule

// File: rtl/bpu_update_queue.sv
// Buffers BHT/BTB training writes and replays them in order when the predictor port is idle.
module bpu_update_queue
    import bpu_update_queue_pkg::*;
#(
    parameter int unsigned DEPTH              = 4,
    parameter int unsigned BHTBTB_INDEX_WIDTH = 9
) (
    input  logic              clock,
    input  logic              reset,
    bpu_update_queue_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic          enq_req;
    logic          deq;
    logic          push;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [31:0]   drop_q;
    entry_t        mem [DEPTH];
    entry_t        new_entry;
    entry_t        head;

    assign enq_req = bus.in_bht_write_enable | (bus.in_btb_ce & bus.in_btb_we);
    assign deq     = !empty && !bus.pred_read_busy;
    // A full queue still accepts when the head leaves in the same cycle
    assign push    = enq_req && (!full || deq) && !reset;

    sync_fifo_ptr #(.DEPTH(DEPTH)) u_ptr (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .pop     (deq),
        .empty   (empty),
        .full    (full),
        .count   (count),
        .wr_addr (wr_addr),
        .rd_addr (rd_addr)
    );

    always_comb begin
        new_entry                    = '0;
        new_entry.bht.v              = bus.in_bht_write_enable;
        new_entry.bht.index          = BHT_INDEX_WIDTH_MAX'(bus.in_bht_write_index);
        new_entry.bht.counter_select = bus.in_bht_write_counter_select;
        new_entry.bht.inc            = bus.in_bht_write_inc;
        new_entry.bht.dec            = bus.in_bht_write_dec;
        new_entry.bht.valid_in       = bus.in_bht_valid_in;
        new_entry.btb.v              = bus.in_btb_ce & bus.in_btb_we;
        new_entry.btb.wmask          = bus.in_btb_wmask;
        new_entry.btb.index          = bus.in_btb_write_index;
        new_entry.btb.din            = bus.in_btb_din;
    end

    // Payload storage carries no reset; validity lives entirely in the pointers
    always_ff @(posedge clock) begin
        if (push) mem[wr_addr] <= new_entry;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            drop_q <= '0;
        end else if (enq_req && full && !deq && (drop_q != 32'hFFFF_FFFF)) begin
            drop_q <= drop_q + 32'd1;
        end
    end

    assign head = mem[rd_addr];

    always_comb begin
        bus.out_bht_write_enable         = 1'b0;
        bus.out_bht_write_index          = '0;
        bus.out_bht_write_counter_select = '0;
        bus.out_bht_write_inc            = 1'b0;
        bus.out_bht_write_dec            = 1'b0;
        bus.out_bht_valid_in             = 1'b0;
        bus.out_btb_ce                   = 1'b0;
        bus.out_btb_we                   = 1'b0;
        bus.out_btb_wmask                = '0;
        bus.out_btb_write_index          = '0;
        bus.out_btb_din                  = '0;
        if (deq) begin
            bus.out_bht_write_enable         = head.bht.v;
            bus.out_bht_write_index          = BHTBTB_INDEX_WIDTH'(head.bht.index);
            bus.out_bht_write_counter_select = head.bht.counter_select;
            bus.out_bht_write_inc            = head.bht.inc;
            bus.out_bht_write_dec            = head.bht.dec;
            bus.out_bht_valid_in             = head.bht.valid_in;
            bus.out_btb_ce                   = head.btb.v;
            bus.out_btb_we                   = head.btb.v;
            bus.out_btb_wmask                = head.btb.wmask;
            bus.out_btb_write_index          = head.btb.index;
            bus.out_btb_din                  = head.btb.din;
        end
    end

    assign bus.queue_full  = full;
    assign bus.queue_count = count;
    assign bus.drop_cnt    = drop_q;

endmodule

// File: tb/tb_bpu_update_queue.sv
// Randomized scoreboard bench for bpu_update_queue against a queue-based reference model.
module tb_bpu_update_queue;
    import bpu_update_queue_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned IW    = 9;

    typedef struct packed {
        logic          bht_we;
        logic [IW-1:0] bht_idx;
        logic [1:0]    sel;
        logic          inc;
        logic          dec;
        logic          vin;
        logic          ce;
        logic          we;
        logic [128:0]  wmask;
        logic [8:0]    btb_idx;
        logic [128:0]  din;
    } out_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    bpu_update_queue_if #(.DEPTH(DEPTH), .BHTBTB_INDEX_WIDTH(IW)) bus ();

    bpu_update_queue #(.DEPTH(DEPTH), .BHTBTB_INDEX_WIDTH(IW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    out_t        exp_q [$];
    entry_t      mq [$];
    int unsigned mdrop = 0;
    int          checks = 0;
    int          failures = 0;
    logic        armed = 1'b0;
    logic        s_chk = 1'b0;
    int unsigned s_count = 0;
    int unsigned s_drop = 0;
    logic        s_full = 1'b0;

    logic [IW-1:0] f_idx;
    logic [1:0]    f_sel;
    logic          f_inc, f_dec, f_vin;
    logic [128:0]  f_wmask, f_din;
    logic [8:0]    f_bidx;

    task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic out_t to_out(input entry_t e);
        out_t o;
        o.bht_we  = e.bht.v;
        o.bht_idx = IW'(e.bht.index);
        o.sel     = e.bht.counter_select;
        o.inc     = e.bht.inc;
        o.dec     = e.bht.dec;
        o.vin     = e.bht.valid_in;
        o.ce      = e.btb.v;
        o.we      = e.btb.v;
        o.wmask   = e.btb.wmask;
        o.btb_idx = e.btb.index;
        o.din     = e.btb.din;
        return o;
    endfunction

    function automatic out_t sample_out();
        out_t o;
        o.bht_we  = bus.out_bht_write_enable;
        o.bht_idx = bus.out_bht_write_index;
        o.sel     = bus.out_bht_write_counter_select;
        o.inc     = bus.out_bht_write_inc;
        o.dec     = bus.out_bht_write_dec;
        o.vin     = bus.out_bht_valid_in;
        o.ce      = bus.out_btb_ce;
        o.we      = bus.out_btb_we;
        o.wmask   = bus.out_btb_wmask;
        o.btb_idx = bus.out_btb_write_index;
        o.din     = bus.out_btb_din;
        return o;
    endfunction

    task automatic rand_fields();
        f_idx   = IW'($urandom);
        f_sel   = 2'($urandom);
        f_inc   = 1'($urandom);
        f_dec   = 1'($urandom);
        f_vin   = 1'($urandom);
        f_bidx  = 9'($urandom);
        f_wmask = {1'($urandom), $urandom, $urandom, $urandom, $urandom};
        f_din   = {1'($urandom), $urandom, $urandom, $urandom, $urandom};
    endtask

    // One cycle of stimulus; the model advances by queue semantics, not by RTL structure.
    task automatic step(input logic rst, input logic busy, input logic bht, input logic ce,
                        input logic we, input logic rnd);
        entry_t e;
        logic   deq_m;
        @(negedge clock);
        if (rnd) rand_fields();
        reset                           = rst;
        bus.pred_read_busy              = busy;
        bus.in_bht_write_enable         = bht;
        bus.in_bht_write_index          = f_idx;
        bus.in_bht_write_counter_select = f_sel;
        bus.in_bht_write_inc            = f_inc;
        bus.in_bht_write_dec            = f_dec;
        bus.in_bht_valid_in             = f_vin;
        bus.in_btb_ce                   = ce;
        bus.in_btb_we                   = we;
        bus.in_btb_wmask                = f_wmask;
        bus.in_btb_write_index          = f_bidx;
        bus.in_btb_din                  = f_din;
        s_chk   = armed;
        s_count = mq.size();
        s_drop  = mdrop;
        s_full  = (mq.size() == DEPTH);
        deq_m = (mq.size() != 0) && !busy;
        if (deq_m) exp_q.push_back(to_out(mq[0]));
        if (rst) begin
            mq.delete();
            mdrop = 0;
        end else begin
            if (deq_m) void'(mq.pop_front());
            if (bht || (ce && we)) begin
                e = '0;
                e.bht.v = bht;
                e.bht.index = BHT_INDEX_WIDTH_MAX'(f_idx);
                e.bht.counter_select = f_sel;
                e.bht.inc = f_inc;
                e.bht.dec = f_dec;
                e.bht.valid_in = f_vin;
                e.btb.v = ce && we;
                e.btb.wmask = f_wmask;
                e.btb.index = f_bidx;
                e.btb.din = f_din;
                if (mq.size() < DEPTH) mq.push_back(e);
                else if (mdrop != 32'hFFFF_FFFF) mdrop++;
            end
        end
    endtask

    // Monitor: status every cycle, write port whenever it fires or is expected to
    initial begin
        out_t o;
        forever begin
            @(negedge clock);
            #1;
            if (s_chk) begin
                o = sample_out();
                chk("queue_count", 320'(bus.queue_count), 320'(s_count));
                chk("drop_cnt", 320'(bus.drop_cnt), 320'(s_drop));
                chk("queue_full", 320'(bus.queue_full), 320'(s_full));
                if (o.bht_we || o.ce || o.we || exp_q.size() != 0) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_write actual=%h required=none", o);
                    end else begin
                        chk("write_port", 320'(o), 320'(exp_q.pop_front()));
                    end
                end else begin
                    chk("idle_zero", 320'(o), 320'(0));
                end
            end
        end
    end

    initial begin
        rand_fields();
        bus.pred_read_busy = 1'b1;
        bus.in_bht_write_enable = 1'b0;
        bus.in_btb_ce = 1'b0;
        bus.in_btb_we = 1'b0;
        step(1, 1, 0, 0, 0, 1);
        armed = 1'b1;
        step(1, 1, 1, 1, 1, 1);

        // Single BHT update
        rand_fields();
        f_idx = 9'h005; f_sel = 2'd2; f_inc = 1'b1; f_dec = 1'b0;
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        // Combined BHT + BTB write
        rand_fields();
        f_bidx  = 9'h1A3;
        f_din   = '0;
        f_din[128] = 1'b1;
        f_din[63:32] = 32'h8000_1000;
        f_wmask = '0;
        f_wmask[128] = 1'b1;
        f_wmask[63:32] = 32'hFFFF_FFFF;
        step(0, 0, 1, 1, 1, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        // Stalled port: fill, then overflow by two
        for (int i = 0; i < 6; i++) step(0, 1, 1, 1, 1, 1);
        step(0, 1, 0, 0, 0, 1);
        #2;
        chk("full_after_fill", 320'(bus.queue_full), 320'(1));
        chk("drops_after_fill", 320'(bus.drop_cnt), 320'(2));
        chk("count_after_fill", 320'(bus.queue_count), 320'(DEPTH));

        // Enqueue against a full queue while the head drains, then drain
        step(0, 0, 1, 0, 0, 1);
        #2;
        chk("count_full_swap", 320'(bus.queue_count), 320'(DEPTH));
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 1);
        #2;
        chk("count_drained", 320'(bus.queue_count), 320'(0));

        // Back-to-back stream across pointer wrap
        for (int i = 0; i < 20; i++) step(0, (i % 8) == 3, 1, 1, 1, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 1);
        #2;
        chk("drops_after_stream", 320'(bus.drop_cnt), 320'(2));

        // Random traffic, including BTB ce without we
        for (int i = 0; i < 200; i++)
            step(0, ($urandom % 3) == 0, 1'($urandom), 1'($urandom), 1'($urandom), 1);

        // Reset with entries queued and a request during reset
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 1);
        step(1, 1, 1, 1, 1, 1);
        step(0, 0, 0, 0, 0, 1);
        #2;
        chk("count_after_reset", 320'(bus.queue_count), 320'(0));
        chk("drops_after_reset", 320'(bus.drop_cnt), 320'(0));
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1);

        #2;
        chk("scoreboard_drained", 320'(exp_q.size()), 320'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
